// File: rtl/serial_half_adder_chain.sv
// Bit-serial adder: two half-adder cells plus a carry flop, one bit per clock, LSB first.
// Optional subtract mode is enabled by defining SERIAL_HALF_ADDER_SUB_EN (adds the `sub` port).
module serial_half_adder_chain #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_HALF_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             p, g1, s, g2;

    // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
`ifdef SERIAL_HALF_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub;
`else
    assign b_load     = b;
    assign carry_load = 1'b0;
`endif

    assign p  = a_sh_q[0] ^ b_sh_q[0];
    assign g1 = a_sh_q[0] & b_sh_q[0];
    assign s  = p ^ carry_q;
    assign g2 = p & carry_q;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b_load;
                    carry_d  = carry_load;
                    cnt_d    = '0;
                    res_sh_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                carry_d  = g1 | g2;
                res_sh_d = {s, res_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    // No same-cycle turnaround: in_ready is low in DONE.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign sum       = res_sh_q;
    assign cout      = carry_q;

endmodule

// File: tb/tb_serial_half_adder_chain.sv
// Directed bench for serial_half_adder_chain; one line per transaction, summary at the end.
module tb_serial_half_adder_chain;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub_i = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int total = 0;
    int bad   = 0;

    serial_half_adder_chain #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
`ifdef SERIAL_HALF_ADDER_SUB_EN
        .sub      (sub_i),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair for a single cycle; the following edge accepts it.
    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv);
        a        = av;
        b        = bv;
        sub_i    = sv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid; -1 if it never arrives.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total++;
        if ({in_ready, out_valid, busy, sum, cout} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b busy=%b sum=%h cout=%b want 1 0 0 00 0",
                     in_ready, out_valid, busy, sum, cout);
        end
        rst = 1'b0;
        tick();
        $display("reset: rdy=%b ov=%b busy=%b", in_ready, out_valid, busy);
    endtask

    task automatic test_add(input logic [7:0] av, input logic [7:0] bv,
                            input logic [7:0] es, input logic ec, input string nm);
        int lat;
        out_ready = 1'b1;
        send(av, bv, 1'b0);
        total++;
        if ({in_ready, busy} !== 2'b01) begin
            bad++;
            $display("FAIL %s_run_flags: got rdy=%b busy=%b want rdy=0 busy=1", nm, in_ready, busy);
        end
        wait_valid(lat);
        total++;
        if (lat !== WIDTH) begin
            bad++;
            $display("FAIL %s_latency: got %0d want %0d", nm, lat, WIDTH);
        end
        total++;
        if ({cout, sum} !== {ec, es}) begin
            bad++;
            $display("FAIL %s_result: got cout=%b sum=%h want cout=%b sum=%h", nm, cout, sum, ec, es);
        end
        tick();
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL %s_return_idle: got rdy=%b ov=%b want rdy=1 ov=0", nm, in_ready, out_valid);
        end
        $display("add %s: a=%h b=%h -> sum=%h cout=%b lat=%0d", nm, av, bv, es, ec, lat);
    endtask

    task automatic test_backpressure();
        int lat;
        logic [8:0] snap;
        out_ready = 1'b0;
        send(8'h03, 8'h04, 1'b0);
        wait_valid(lat);
        total++;
        if (lat !== WIDTH || {cout, sum} !== 9'h007) begin
            bad++;
            $display("FAIL bp_first: got lat=%0d cout=%b sum=%h want lat=%0d 0 07", lat, cout, sum, WIDTH);
        end
        snap = {cout, sum};
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || {cout, sum} !== 9'h007) begin
                bad++;
                $display("FAIL bp_hold_%0d: got ov=%b cout=%b sum=%h want 1 0 07", i, out_valid, cout, sum);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL bp_release: got rdy=%b ov=%b want 1 0", in_ready, out_valid);
        end
        $display("backpressure: held result %h for 20 cycles", snap);
    endtask

    task automatic test_ignore_in_run();
        int lat;
        int extra;
        out_ready = 1'b1;
        send(8'h12, 8'h34, 1'b0);
        tick();
        tick();
        a        = 8'h33;
        b        = 8'h33;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        total++;
        if (lat !== WIDTH - 3 || {cout, sum} !== 9'h046) begin
            bad++;
            $display("FAIL ignore_result: got lat=%0d cout=%b sum=%h want lat=%0d 0 46",
                     lat, cout, sum, WIDTH - 3);
        end
        extra = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (out_valid) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL ignore_no_second: got %0d extra out_valid cycles want 0", extra);
        end
        $display("ignore: a=12 b=34 delivered sum=46, extra=%0d", extra);
    endtask

    task automatic test_reset_mid_run();
        int seen;
        out_ready = 1'b1;
        send(8'h0F, 8'h01, 1'b0);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({in_ready, out_valid, busy, sum, cout} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL midrst_async: got rdy=%b ov=%b busy=%b sum=%h cout=%b want 1 0 0 00 0",
                     in_ready, out_valid, busy, sum, cout);
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({in_ready, busy} !== 2'b10) begin
            bad++;
            $display("FAIL midrst_release: got rdy=%b busy=%b want 1 0", in_ready, busy);
        end
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midrst_no_valid: got %0d out_valid cycles want 0", seen);
        end
        $display("reset mid-run: aborted, out_valid cycles=%0d", seen);
    endtask

`ifdef SERIAL_HALF_ADDER_SUB_EN
    task automatic test_sub(input logic [7:0] av, input logic [7:0] bv,
                            input logic [7:0] es, input logic ec, input string nm);
        int lat;
        out_ready = 1'b1;
        send(av, bv, 1'b1);
        sub_i = 1'b0;
        wait_valid(lat);
        total++;
        if (lat !== WIDTH || {cout, sum} !== {ec, es}) begin
            bad++;
            $display("FAIL %s: got lat=%0d cout=%b sum=%h want lat=%0d cout=%b sum=%h",
                     nm, lat, cout, sum, WIDTH, ec, es);
        end
        tick();
        $display("sub %s: a=%h b=%h -> sum=%h cout=%b", nm, av, bv, es, ec);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add(8'h0F, 8'h01, 8'h10, 1'b0, "0f_01");
        test_add(8'hFF, 8'h01, 8'h00, 1'b1, "ff_01");
        test_add(8'hA5, 8'h5A, 8'hFF, 1'b0, "a5_5a");
        test_add(8'h80, 8'h80, 8'h00, 1'b1, "80_80");
        test_backpressure();
        test_ignore_in_run();
        test_reset_mid_run();
`ifdef SERIAL_HALF_ADDER_SUB_EN
        test_sub(8'h05, 8'h07, 8'hFE, 1'b0, "sub_05_07");
        test_sub(8'h07, 8'h05, 8'h02, 1'b1, "sub_07_05");
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
